global_sram_wr_ctrl: RTL and testbench



---
 rtl/global_sram_pkg.sv | 45 ++++
 rtl/global_sram_wr_ctrl_beat_packer.sv | 44 ++++
 rtl/global_sram_wr_ctrl.sv | 143 ++++++++++++++
 tb/tb_global_sram_wr_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/global_sram_pkg.sv
// Shared definitions for the global SRAM controllers: phase codes, model_cfg
// field layout, default widths and the write-controller FSM encoding.
package global_sram_pkg;

    localparam int unsigned BEAT_W_DEF = 32;
    localparam int unsigned PACK_DEF   = 4;
    localparam int unsigned LINE_W_DEF = 128;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned CS_W       = 32;
    localparam int unsigned CFG_W      = 30;
    localparam int unsigned EMBD_LSB   = 1;
    localparam int unsigned EMBD_W     = 10;
    localparam int unsigned LINES_W    = 6;
    localparam int unsigned LINE_SHIFT = 4;

    localparam logic [CS_W-1:0] CS_IDLE = 32'd0;
    localparam logic [CS_W-1:0] CS_PH1  = 32'd1;
    localparam logic [CS_W-1:0] CS_PH2  = 32'd2;
    localparam logic [CS_W-1:0] CS_PH3  = 32'd3;
    localparam logic [CS_W-1:0] CS_PH4  = 32'd4;
    localparam logic [CS_W-1:0] CS_PH5  = 32'd5;
    localparam logic [CS_W-1:0] CS_PH6  = 32'd6;
    localparam logic [CS_W-1:0] CS_PH7  = 32'd7;
    localparam logic [CS_W-1:0] CS_PH8  = 32'd8;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_ARMED = 2'd1,
        WR_DONE  = 2'd2
    } wr_state_e;

    // Phases whose core results are streamed back as beats.
    function automatic logic is_stream(input logic [CS_W-1:0] cs);
        return (cs == CS_PH1) || (cs == CS_PH2) || (cs == CS_PH3) || (cs == CS_PH7);
    endfunction

    function automatic logic is_nowrite(input logic [CS_W-1:0] cs);
        return (cs == CS_PH4) || (cs == CS_PH5) || (cs == CS_PH6);
    endfunction

    function automatic logic [LINES_W-1:0] lines_of(input logic [CFG_W-1:0] cfg);
        return LINES_W'(cfg[EMBD_LSB +: EMBD_W] >> LINE_SHIFT);
    endfunction

endpackage

// File: rtl/global_sram_wr_ctrl_beat_packer.sv
// Collects PACK beats into one SRAM line; slot 0 lands in the low bits.
// The line-ready strobe and assembled line are combinational on the last beat.
module beat_packer
    import global_sram_pkg::*;
#(
    parameter int unsigned BEAT_W = BEAT_W_DEF,
    parameter int unsigned PACK   = PACK_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              beat_vld_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic              line_rdy_c_o,
    output logic [LINE_W-1:0] line_data_c_o
);

    localparam int unsigned CNT_W = (PACK > 1) ? $clog2(PACK) : 1;

    logic [CNT_W-1:0]  beat_cnt_q;
    logic [LINE_W-1:0] pack_q;
    logic [LINE_W-1:0] merged_c;

    // Current pack with the incoming beat already dropped into its slot.
    always_comb begin
        merged_c = pack_q;
        merged_c[32'(beat_cnt_q) * BEAT_W +: BEAT_W] = beat_i;
    end

    assign line_rdy_c_o  = beat_vld_i && (beat_cnt_q == CNT_W'(PACK - 1));
    assign line_data_c_o = merged_c;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            beat_cnt_q <= '0;
            pack_q     <= '0;
        end else if (beat_vld_i) begin
            pack_q     <= merged_c;
            beat_cnt_q <= (beat_cnt_q == CNT_W'(PACK - 1)) ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/global_sram_wr_ctrl.sv
// Global SRAM write controller: packs streamed beats into sequential line
// writes per phase, or forwards caller-addressed lines in the direct phase.
module global_sram_wr_ctrl
    import global_sram_pkg::*;
#(
    parameter int unsigned BEAT_W = BEAT_W_DEF,
    parameter int unsigned PACK   = PACK_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CS_W-1:0]   control_state,
    input  logic              control_state_update,
    input  logic              model_cfg_vld,
    input  logic [CFG_W-1:0]  model_cfg,
    input  logic              start,
    output logic              finish,
    input  logic [BEAT_W-1:0] in_beat,
    input  logic              in_beat_vld,
    input  logic [LINE_W-1:0] in_line,
    input  logic [ADDR_W-1:0] in_line_addr,
    input  logic              in_line_vld,
    output logic              global_sram_wen,
    output logic [ADDR_W-1:0] global_sram_waddr,
    output logic [LINE_W-1:0] global_sram_wdata,
    output logic              wr_overflow
);

    logic [CS_W-1:0]    cs_q;
    logic [CFG_W-1:0]   cfg_q;
    logic               start_q;
    wr_state_e          state_q, state_d;
    logic [LINES_W-1:0] line_cnt_q;
    logic               finish_q, wen_q, ovf_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [LINE_W-1:0]  wdata_q;

    logic [LINES_W-1:0] lines_c;
    logic               stream_c, nowr_c, direct_c;
    logic               abort_c, clear_c, accept_c, last_wr_c;
    logic               line_rdy_c;
    logic [LINE_W-1:0]  line_data_c;

    assign lines_c   = lines_of(cfg_q);
    assign stream_c  = is_stream(cs_q);
    assign nowr_c    = is_nowrite(cs_q);
    assign direct_c  = (cs_q == CS_PH8);
    assign abort_c   = control_state_update && (control_state != cs_q) && (state_q == WR_ARMED);
    assign clear_c   = start_q || abort_c;
    assign accept_c  = in_beat_vld && stream_c && (state_q == WR_ARMED) && !abort_c
                       && (line_cnt_q != lines_c);
    assign last_wr_c = wen_q && (line_cnt_q == lines_c);

    beat_packer #(
        .BEAT_W (BEAT_W),
        .PACK   (PACK),
        .LINE_W (LINE_W)
    ) u_packer (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (clear_c),
        .beat_vld_i    (accept_c),
        .beat_i        (in_beat),
        .line_rdy_c_o  (line_rdy_c),
        .line_data_c_o (line_data_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q    <= CS_IDLE;
            cfg_q   <= '0;
            start_q <= 1'b0;
        end else begin
            if (control_state_update) cs_q  <= control_state;
            if (model_cfg_vld)        cfg_q <= model_cfg;
            start_q <= start;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WR_IDLE;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            finish_q <= (state_d == WR_DONE);
        end
    end

    // Abort beats restart; restart beats completion of the last line.
    always_comb begin
        state_d = state_q;
        if (abort_c) begin
            state_d = WR_IDLE;
        end else if (start_q && stream_c) begin
            state_d = (lines_c == '0) ? WR_DONE : WR_ARMED;
        end else if (start_q && nowr_c) begin
            state_d = WR_DONE;
        end else begin
            case (state_q)
                WR_ARMED: if (last_wr_c) state_d = WR_DONE;
                WR_DONE:  state_d = WR_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            line_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            if (direct_c) begin
                wen_q <= in_line_vld;
                if (in_line_vld) begin
                    waddr_q <= in_line_addr;
                    wdata_q <= in_line;
                end
            end else if (line_rdy_c) begin
                wen_q   <= 1'b1;
                waddr_q <= ADDR_W'(line_cnt_q);
                wdata_q <= line_data_c;
            end
            if (clear_c)         line_cnt_q <= '0;
            else if (line_rdy_c) line_cnt_q <= line_cnt_q + LINES_W'(1);
            // A stray beat in the same cycle as the restart still counts as dropped.
            if (start_q) ovf_q <= 1'b0;
            if (in_beat_vld && stream_c && (state_q != WR_ARMED)) ovf_q <= 1'b1;
        end
    end

    assign finish            = finish_q;
    assign global_sram_wen   = wen_q;
    assign global_sram_waddr = waddr_q;
    assign global_sram_wdata = wdata_q;
    assign wr_overflow       = ovf_q;

endmodule

// File: tb/tb_global_sram_wr_ctrl.sv
// Directed bench for global_sram_wr_ctrl: reset, streamed packing, no-write
// phases, direct writes, abort/restart and overflow handling.
module tb_global_sram_wr_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  control_state;
    logic         control_state_update;
    logic         model_cfg_vld;
    logic [29:0]  model_cfg;
    logic         start;
    logic         finish;
    logic [31:0]  in_beat;
    logic         in_beat_vld;
    logic [127:0] in_line;
    logic [4:0]   in_line_addr;
    logic         in_line_vld;
    logic         global_sram_wen;
    logic [4:0]   global_sram_waddr;
    logic [127:0] global_sram_wdata;
    logic         wr_overflow;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    global_sram_wr_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .control_state        (control_state),
        .control_state_update (control_state_update),
        .model_cfg_vld        (model_cfg_vld),
        .model_cfg            (model_cfg),
        .start                (start),
        .finish               (finish),
        .in_beat              (in_beat),
        .in_beat_vld          (in_beat_vld),
        .in_line              (in_line),
        .in_line_addr         (in_line_addr),
        .in_line_vld          (in_line_vld),
        .global_sram_wen      (global_sram_wen),
        .global_sram_waddr    (global_sram_waddr),
        .global_sram_wdata    (global_sram_wdata),
        .wr_overflow          (wr_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_phase(input logic [31:0] cs, input logic [9:0] embd);
        control_state        = cs;
        control_state_update = 1'b1;
        model_cfg            = 30'({embd, 1'b0});
        model_cfg_vld        = 1'b1;
        step();
        control_state_update = 1'b0;
        model_cfg_vld        = 1'b0;
    endtask

    // Start at cycle t; returns at cycle t+2 where the phase is armed.
    task automatic start_phase();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    // Consecutive beats base+i; each completed group of four must write line i/4.
    task automatic stream(input logic [31:0] base, input int nbeats, input bit exp_fin);
        logic [127:0] exp_line;
        for (int i = 0; i < nbeats; i++) begin
            in_beat     = base + 32'(i);
            in_beat_vld = 1'b1;
            step();
            chk("stream_wen", 128'(global_sram_wen), 128'(i % 4 == 3));
            chk("stream_fin", 128'(finish), 128'(0));
            if (i % 4 == 3) begin
                for (int j = 0; j < 4; j++)
                    exp_line[j*32 +: 32] = base + 32'(i - 3 + j);
                chk("stream_addr", 128'(global_sram_waddr), 128'(i / 4));
                chk("stream_data", global_sram_wdata, exp_line);
            end
        end
        in_beat_vld = 1'b0;
        step();
        chk("fin_pulse", 128'(finish), 128'(exp_fin));
        chk("fin_no_wen", 128'(global_sram_wen), 128'(0));
        step();
        chk("fin_drop", 128'(finish), 128'(0));
    endtask

    initial begin
        rst = 1'b1; control_state = '0; control_state_update = 1'b0;
        model_cfg_vld = 1'b0; model_cfg = '0; start = 1'b0;
        in_beat = '0; in_beat_vld = 1'b0; in_line = '0; in_line_addr = '0; in_line_vld = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            control_state = $urandom; control_state_update = 1'($urandom);
            model_cfg = 30'($urandom); model_cfg_vld = 1'($urandom); start = 1'($urandom);
            in_beat = $urandom; in_beat_vld = 1'($urandom);
            in_line = {$urandom, $urandom, $urandom, $urandom};
            in_line_addr = 5'($urandom); in_line_vld = 1'($urandom);
            step();
        end
        chk("rst_finish", 128'(finish), 128'(0));
        chk("rst_wen", 128'(global_sram_wen), 128'(0));
        chk("rst_waddr", 128'(global_sram_waddr), 128'(0));
        chk("rst_wdata", global_sram_wdata, 128'(0));
        chk("rst_ovf", 128'(wr_overflow), 128'(0));
        rst = 1'b0; control_state = '0; control_state_update = 1'b0;
        model_cfg = '0; model_cfg_vld = 1'b0; start = 1'b0;
        in_beat = '0; in_beat_vld = 1'b0; in_line = '0; in_line_addr = '0; in_line_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_wen", 128'(global_sram_wen), 128'(0));
        end

        // Phase 1, embd=64: four lines at addr 0..3
        set_phase(32'd1, 10'd64);
        start_phase();
        chk("p1_armed_fin", 128'(finish), 128'(0));
        stream(32'h0, 16, 1'b1);
        chk("p1_ovf", 128'(wr_overflow), 128'(0));

        // Phase 5: finish two cycles after start, no write
        set_phase(32'd5, 10'd64);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("p5_fin_early", 128'(finish), 128'(0));
        step();
        chk("p5_fin", 128'(finish), 128'(1));
        chk("p5_wen", 128'(global_sram_wen), 128'(0));
        step();
        chk("p5_fin_drop", 128'(finish), 128'(0));

        // Phase 1 with embd=0: immediate finish
        set_phase(32'd1, 10'd0);
        start_phase();
        chk("e0_fin", 128'(finish), 128'(1));
        chk("e0_wen", 128'(global_sram_wen), 128'(0));
        step();
        chk("e0_fin_drop", 128'(finish), 128'(0));

        // Phase 8: direct writes, beats ignored
        set_phase(32'd8, 10'd64);
        in_line_vld = 1'b1; in_line_addr = 5'd7; in_line = 128'h11112222_33334444_55556666_77778888;
        in_beat_vld = 1'b1;
        step();
        chk("d0_wen", 128'(global_sram_wen), 128'(1));
        chk("d0_addr", 128'(global_sram_waddr), 128'(7));
        chk("d0_data", global_sram_wdata, 128'h11112222_33334444_55556666_77778888);
        in_line_addr = 5'd2; in_line = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
        in_beat_vld = 1'b0;
        step();
        chk("d1_wen", 128'(global_sram_wen), 128'(1));
        chk("d1_addr", 128'(global_sram_waddr), 128'(2));
        chk("d1_data", global_sram_wdata, 128'hDEADBEEF_00000000_CAFEF00D_12345678);
        in_line_addr = 5'd31; in_line = 128'hFFFFFFFF_0F0F0F0F_A5A5A5A5_00000001;
        in_beat_vld = 1'b1;
        step();
        chk("d2_wen", 128'(global_sram_wen), 128'(1));
        chk("d2_addr", 128'(global_sram_waddr), 128'(31));
        chk("d2_data", global_sram_wdata, 128'hFFFFFFFF_0F0F0F0F_A5A5A5A5_00000001);
        in_line_vld = 1'b0; in_line = '0; in_line_addr = '0; in_beat_vld = 1'b0;
        step();
        chk("d3_wen", 128'(global_sram_wen), 128'(0));
        chk("d3_addr_hold", 128'(global_sram_waddr), 128'(31));
        chk("d3_data_hold", global_sram_wdata, 128'hFFFFFFFF_0F0F0F0F_A5A5A5A5_00000001);
        chk("d3_fin", 128'(finish), 128'(0));
        chk("d3_ovf", 128'(wr_overflow), 128'(0));

        // Phase 2, embd=32: abort after six beats
        set_phase(32'd2, 10'd32);
        start_phase();
        stream(32'h100, 6, 1'b0);
        control_state = 32'd3; control_state_update = 1'b1;
        step();
        control_state_update = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_fin", 128'(finish), 128'(0));
            chk("abort_wen", 128'(global_sram_wen), 128'(0));
            step();
        end
        // Fresh start in phase 3 begins at addr 0 with no leftover beats
        start_phase();
        stream(32'h200, 8, 1'b1);

        // Stray beat between start and arming
        start = 1'b1;
        step();
        start = 1'b0;
        in_beat = 32'hDEAD; in_beat_vld = 1'b1;
        step();
        in_beat_vld = 1'b0;
        chk("ovf_set", 128'(wr_overflow), 128'(1));
        stream(32'h300, 8, 1'b1);
        step();
        chk("ovf_sticky", 128'(wr_overflow), 128'(1));
        start_phase();
        chk("ovf_clear", 128'(wr_overflow), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
